// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the multi-channel arbitrated RAM target.
package mem_arb_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // A single channel still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_ram_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr, ptr+1, ... mod N and grants the first requester.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  always_comb begin
    logic [IW:0] pos;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit holds ptr+i before the modulo wrap.
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= N_EXT) pos = pos - N_EXT;
      if (!gnt_any && req[pos[IW-1:0]]) begin
        gnt[pos[IW-1:0]] = 1'b1;
        gnt_idx          = pos[IW-1:0];
        gnt_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb_ram.sv
// N-channel register-file RAM target with round-robin grant and a 1-cycle registered read return.
// Optional per-channel grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arb_ram
  import mem_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          we,
  input  logic [N_CH*ADDR_W-1:0]   addr,
  input  logic [N_CH*DATA_W-1:0]   wdata,
  output logic [N_CH-1:0]          gnt,
  output logic [N_CH-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  input  logic                     stat_clr,
  output logic [N_CH*CNT_W-1:0]    stat_cnt
);

  localparam int IW = idx_w(N_CH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [N_CH-1:0]   arb_gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              xfer;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [N_CH-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  op_e               sel_op;
  logic              in_range;

  rr_arbiter #(.N(N_CH), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign gnt  = rst_n ? arb_gnt : '0;
  assign xfer = gnt_any & rst_n;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_op    = OP_RD;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_op    = op_e'(we[i]);
      end
    end
  end

  assign in_range = {1'b0, sel_addr} < DEPTH_L;

  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (xfer) begin
      ptr_d = (gnt_idx == IW'(N_CH-1)) ? '0 : gnt_idx + IW'(1);
      if (sel_op == OP_RD) begin
        rvalid_d = gnt;
        rdata_d  = in_range ? mem[sel_addr] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM contents survive reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (xfer && sel_op == OP_WR && in_range) mem[sel_addr] <= sel_wdata;
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Clear takes precedence over a same-cycle grant; counts saturate at all-ones.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr)                        cnt_d[i] = '0;
      else if (gnt[i] && cnt_q[i] != '1)   cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < N_CH; i++) stat_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_mem_arb_ram.sv
// Self-checking bench for mem_arb_ram: directed vector table, reset corner cases and
// randomized traffic against a behavioural model.
module tb_mem_arb_ram;
  import mem_arb_pkg::*;

  localparam int N     = 4;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      we = '0;
  logic [N*AW-1:0]   addr = '0;
  logic [N*DW-1:0]   wdata = '0;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [DW-1:0]     rdata;
  logic              stat_clr = 1'b0;
  logic [N*CNT_W-1:0] stat_cnt;

  mem_arb_ram #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int         m_ptr;
  logic [7:0] m_mem [16];
  logic [7:0] m_rdata;
  int         m_cnt [N];
  logic [3:0] m_gnt, m_rvalid, dut_gnt;

  typedef struct {
    logic [3:0]  req, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [7:0]  rdata;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] model_grant(input logic [3:0] r);
    for (int i = 0; i < N; i++) begin
      int c = (m_ptr + i) % N;
      if (r[c]) return 4'(1) << c;
    end
    return 4'b0;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_rdata = 8'h00;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // Drives one op set at posedge+1, checks grant at negedge, checks returns at next posedge+1.
  task automatic do_cycle(input logic [3:0] r, input logic [3:0] w, input logic [15:0] a,
                          input logic [31:0] d, input logic clr, input string nm);
    int k;
    logic [3:0] ch_addr;
    req = r; we = w; addr = a; wdata = d; stat_clr = clr;
    m_gnt = model_grant(r);
    @(negedge clk);
    dut_gnt = gnt;
    check({nm, "_gnt"}, 64'(gnt), 64'(m_gnt));
    @(posedge clk); #1;
    m_rvalid = '0;
    if (m_gnt != 4'b0) begin
      k = $clog2(m_gnt);
      ch_addr = a[k*4 +: 4];
      m_ptr = (k + 1) % N;
      if (w[k]) begin
        if (ch_addr < DEPTH) m_mem[ch_addr] = d[k*8 +: 8];
      end else begin
        m_rvalid = m_gnt;
        m_rdata  = (ch_addr < DEPTH) ? m_mem[ch_addr] : 8'h00;
      end
      if (m_cnt[k] < 65535) m_cnt[k]++;
    end
    if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    check({nm, "_rvalid"}, 64'(rvalid), 64'(m_rvalid));
    check({nm, "_rdata"}, 64'(rdata), 64'(m_rdata));
`ifdef MEM_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check({nm, "_cnt"}, 64'(stat_cnt[i*CNT_W +: CNT_W]), 64'(m_cnt[i]));
`else
    check({nm, "_cnt_off"}, 64'(stat_cnt), 64'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       pend [N];
    logic [3:0] p_we, p_r;
    logic [15:0] p_addr;
    logic [31:0] p_data;
    int         waitc [N];

    // ch addrs {3,5,3,0}: ch0 reads 0x11, ch1/ch3 read 0xA5, ch2 reads 0x3C
    tbl[0]  = '{4'hF, 4'hF, 16'h0000, 32'h0000_0011, 4'h1, 4'h0, 8'h00};
    tbl[1]  = '{4'h2, 4'h2, 16'h0030, 32'h0000_A500, 4'h2, 4'h0, 8'h00};
    tbl[2]  = '{4'h4, 4'h0, 16'h0300, 32'h0000_0000, 4'h4, 4'h4, 8'hA5};
    tbl[3]  = '{4'h8, 4'h8, 16'h5000, 32'h3C00_0000, 4'h8, 4'h0, 8'hA5};
    tbl[4]  = '{4'hF, 4'h0, 16'h3530, 32'h0, 4'h1, 4'h1, 8'h11};
    tbl[5]  = '{4'hF, 4'h0, 16'h3530, 32'h0, 4'h2, 4'h2, 8'hA5};
    tbl[6]  = '{4'hF, 4'h0, 16'h3530, 32'h0, 4'h4, 4'h4, 8'h3C};
    tbl[7]  = '{4'hF, 4'h0, 16'h3530, 32'h0, 4'h8, 4'h8, 8'hA5};
    tbl[8]  = '{4'hF, 4'h0, 16'h3530, 32'h0, 4'h1, 4'h1, 8'h11};
    tbl[9]  = '{4'hF, 4'h0, 16'h3530, 32'h0, 4'h2, 4'h2, 8'hA5};
    tbl[10] = '{4'hF, 4'h0, 16'h3530, 32'h0, 4'h4, 4'h4, 8'h3C};
    tbl[11] = '{4'hF, 4'h0, 16'h3530, 32'h0, 4'h8, 4'h8, 8'hA5};
    tbl[12] = '{4'h1, 4'h1, 16'h000E, 32'h0000_005A, 4'h1, 4'h0, 8'hA5};
    tbl[13] = '{4'h1, 4'h0, 16'h000E, 32'h0000_0000, 4'h1, 4'h1, 8'h00};

    req = 4'hF;
    #12;
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_rvalid", 64'(rvalid), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_cnt", 64'(stat_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 14; i++) begin
      do_cycle(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("tbl%0d_gnt", i), 64'(dut_gnt), 64'(tbl[i].gnt));
      check($sformatf("tbl%0d_rvalid", i), 64'(rvalid), 64'(tbl[i].rvalid));
      check($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(tbl[i].rdata));
    end

    // Reset lands on the edge that would have returned ch3's read.
    req = 4'b1000; we = 4'b0; addr = 16'h3000; stat_clr = 1'b0;
    @(negedge clk);
    check("rstmid_gnt", 64'(gnt), 64'b1000);
    #1 rst_n = 1'b0;
    #1 check("rstmid_gnt_forced", 64'(gnt), 64'd0);
    @(posedge clk); #1;
    check("rstmid_rvalid", 64'(rvalid), 64'd0);
    check("rstmid_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;
    model_reset();
    do_cycle(4'hF, 4'h0, 16'h3530, 32'h0, 1'b0, "post_rst");
    check("post_rst_ptr0", 64'(dut_gnt), 64'b0001);

`ifdef MEM_ARB_STATS_EN
    do_cycle(4'h0, 4'h0, 16'h0, 32'h0, 1'b1, "st_clr0");
    repeat (5) do_cycle(4'h1, 4'h1, 16'h0002, 32'h77, 1'b0, "st_inc");
    check("stat_five", 64'(stat_cnt[15:0]), 64'd5);
    do_cycle(4'h1, 4'h1, 16'h0002, 32'h77, 1'b1, "st_clr_win");
    check("stat_clr_wins", 64'(stat_cnt[15:0]), 64'd0);
    do_cycle(4'h1, 4'h1, 16'h0002, 32'h77, 1'b0, "st_after");
    check("stat_after_clr", 64'(stat_cnt[15:0]), 64'd1);
`endif

    for (int i = 0; i < DEPTH; i++)
      do_cycle(4'h1, 4'h1, 16'(i), 32'(8'(i * 17 + 3)), 1'b0, "init");

    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; waitc[i] = 0; end
    p_we = '0; p_addr = '0; p_data = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c] && $urandom_range(0, 1) == 1) begin
          pend[c]            = 1'b1;
          p_we[c]            = 1'($urandom_range(0, 1));
          p_addr[c*4 +: 4]   = 4'($urandom_range(0, 15));
          p_data[c*8 +: 8]   = 8'($urandom);
        end
        p_r[c] = pend[c];
      end
      do_cycle(p_r, p_we, p_addr, p_data, 1'($urandom_range(0, 15) == 0), "rnd");
      for (int c = 0; c < N; c++) begin
        if (dut_gnt[c]) begin
          check("starve_bound", 64'(waitc[c] <= N - 1), 64'd1);
          waitc[c] = 0;
          pend[c]  = 1'b0;
        end else if (pend[c]) begin
          waitc[c]++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
